// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Purpose  : Boot-time loader. Receives a length-prefixed, XOR-checksummed
//            byte stream and writes little-endian 32-bit words into the
//            instruction memory starting at BASE_ADDR. busy holds the CPU off.
// Revision : 1.0 - initial release
// ============================================================================
module instr_loader #(
  parameter int unsigned               DATA_WIDTH        = 8,
  parameter int unsigned               ADDRESS_WIDTH     = 32,
  parameter int unsigned               INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]  BASE_ADDR         = 32'hBFC00000,
  parameter int unsigned               MEM_BYTES         = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          byte_valid,
  input  logic [DATA_WIDTH-1:0]         byte_data,
  output logic                          byte_ready,
  output logic                          we,
  output logic [ADDRESS_WIDTH-1:0]      waddr,
  output logic [INSTRUCTION_WIDTH-1:0]  wdata,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  // Byte counter holds values up to MEM_BYTES without wrapping.
  localparam int unsigned CNT_W   = $clog2(MEM_BYTES + 1);
  localparam int unsigned SHIFT_W = INSTRUCTION_WIDTH - DATA_WIDTH;
  localparam int unsigned LEN_W   = 2 * DATA_WIDTH;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_LO  = 3'd1;
  localparam logic [2:0] S_LEN_HI  = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] len_lo;
  logic [CNT_W-1:0]      len;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] checksum;
  logic [SHIFT_W-1:0]    shift;

  logic                  accept;
  logic [LEN_W-1:0]      length;
  logic                  len_ok;
  logic                  last_byte;
  logic                  lane3;
  logic [CNT_W-1:0]      word_offset;

  // Session is active (and bytes are taken unconditionally) between start and the checksum.
  always_comb begin
    busy       = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                 (state == S_PAYLOAD) || (state == S_CHECK);
    byte_ready = busy;
    accept     = byte_valid && byte_ready;
    length     = {byte_data, len_lo};
    len_ok     = (length != '0) && (length[1:0] == 2'b00) &&
                 (32'(length) <= 32'(MEM_BYTES));
    last_byte  = (count == (len - CNT_ONE));
    lane3      = (count[1:0] == 2'b11);
    word_offset = {count[CNT_W-1:2], 2'b00};
  end

  // Session FSM, word assembly, checksum accumulation and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      len_lo   <= '0;
      len      <= '0;
      count    <= '0;
      checksum <= '0;
      shift    <= '0;
      we       <= 1'b0;
      waddr    <= BASE_ADDR;
      wdata    <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state    <= S_LEN_LO;
            done     <= 1'b0;
            error    <= 1'b0;
            checksum <= '0;
            count    <= '0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_lo <= byte_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            if (len_ok) begin
              len   <= length[CNT_W-1:0];
              state <= S_PAYLOAD;
            end else begin
              error <= 1'b1;
              state <= S_ERROR;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            checksum <= checksum ^ byte_data;
            shift    <= {byte_data, shift[SHIFT_W-1:DATA_WIDTH]};
            count    <= count + CNT_ONE;
            // Lane 3 completes a word: older bytes sit in the low lanes.
            if (lane3) begin
              we    <= 1'b1;
              waddr <= BASE_ADDR + ADDRESS_WIDTH'(word_offset);
              wdata <= {byte_data, shift};
            end
            if (last_byte) begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          // Already-written words stay in memory regardless of the outcome.
          if (accept) begin
            if (byte_data == checksum) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_ERROR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader that fills the instruction ROM region over a byte-serial stream. It receives a length-prefixed, checksummed byte stream on a valid/ready interface and assembles little-endian 32-bit words. It writes them to the instruction memory's write port at byte addresses starting at BASE_ADDR. The CPU is held off while a load is in progress. It is the write-side counterpart of the asynchronous little-endian instruction fetch memory.

## Interface

- DATA_WIDTH, 8, stream byte width
- ADDRESS_WIDTH, 32, write address width
- INSTRUCTION_WIDTH, 32, assembled word width
- BASE_ADDR, 32'hBFC00000, byte address of first written word
- MEM_BYTES, 4096, region size; maximum legal length

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load session (sampled in IDLE/DONE/ERROR only)
- byte_valid  in  1  byte_data is valid
- byte_data  in  DATA_WIDTH  stream byte
- byte_ready  out  1  loader accepts byte this cycle
- we  out  1  one-cycle write strobe to instruction memory
- waddr  out  ADDRESS_WIDTH  byte address of word (multiple of 4)
- wdata  out  INSTRUCTION_WIDTH  word; first received byte in [7:0]
- busy  out  1  session active; CPU held in reset while high
- done  out  1  session completed with good checksum (sticky)
- error  out  1  session failed (sticky)

## Operation

- Stream format: LEN_LO, LEN_HI (byte count N, little-endian), N payload bytes, 1 checksum byte = XOR of all payload bytes (header excluded).
- Byte accepted on rising edge with byte_valid && byte_ready.
- FSM states: IDLE, LEN_LO, LEN_HI, PAYLOAD, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR: start=1 -> LEN_LO; clears done, error, checksum, byte counter. start ignored in all other states.
- LEN_LO: accept -> LEN_HI. LEN_HI: accept -> validate N.
- N valid iff N != 0, N[1:0] == 0, N <= MEM_BYTES. Valid -> PAYLOAD; invalid -> ERROR.
- PAYLOAD: each accepted byte shifts into word at lane offset[1:0] and XORs into checksum. Offset increments by 1. On acceptance of lane 3, the word is written. After the N-th byte -> CHECK.
- CHECK: accept -> DONE if byte == checksum, else ERROR. Words already written are not rolled back.
- busy = 1 in LEN_LO, LEN_HI, PAYLOAD, CHECK.
- byte_ready = busy (no internal backpressure).
- Partial words are never written. Counters are sized for MEM_BYTES with no wrap.

## Timing

- Reset (async, immediate): state IDLE; byte_ready, we, busy, done, error = 0; waddr = BASE_ADDR; wdata = 0.
- we, waddr, wdata are registered. we is high for exactly the one cycle after the edge that accepted lane 3. waddr = BASE_ADDR + 4·k for the k-th word (k from 0); wdata = {b3,b2,b1,b0}.
- Streaming: one byte per cycle is sustained. Writes occur at most every 4 cycles. byte_valid gaps only stall progress.
- start -> busy/byte_ready high on next cycle.
- Invalid length: ERROR on the cycle after the LEN_HI edge. byte_ready drops the same cycle and no payload is consumed.
- Last payload byte: the write pulse occurs in the first CHECK cycle. A checksum byte presented that cycle is accepted.
- done/error assert the cycle after the deciding edge and hold until start or reset.
- Reset mid-session: abort. An in-flight we is cleared asynchronously. Completed writes remain in memory.

## Test plan

- Reset: assert rst_n=0 with stream active -> all outputs at reset values at once, including we=0 mid-pulse.
- Good load: start, stream 08 00 13 05 A0 00 93 05 10 00 30 back-to-back -> we pulses with (BFC00000, 00A00513) then (BFC00004, 00100593); done=1, error=0, busy=0.
- Bad checksum: same stream with trailer 31 -> both writes still occur; error=1, done=0.
- Invalid length: headers 06 00, 00 00, 04 10 (4100) -> error=1 after header, no we, byte_ready=0; N=00 10 (4096) accepted and last write at BFC00FFC.
- Valid gaps: good-load stream with byte_valid randomly low 50% -> identical write sequence and done; start pulsed mid-session is ignored.
- Reset mid-payload after 6 payload bytes -> exactly one write seen; a fresh start and good stream then completes normally.
